// File: rtl/dmem_bank.sv
// Single-port data memory for the LSU DMEM interface. It decodes the access size, steers bytes
// onto their lanes and right-aligns load data. A zeroing sweep runs after reset.

`ifndef DMEM_MIN
`define DMEM_MIN 32'h0001_0000
`endif
`ifndef DMEM_MAX
`define DMEM_MAX 32'h0001_FFFF
`endif
`ifndef LDB_CONF
`define LDB_CONF  4'd0
`define LDH_CONF  4'd1
`define LDW_CONF  4'd2
`define LDBU_CONF 4'd3
`define LDHU_CONF 4'd4
`define STB_CONF  4'd5
`define STH_CONF  4'd6
`define STW_CONF  4'd7
`endif

module dmem_bank #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] BASE_ADDR  = `DMEM_MIN,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd_dmem,
  input  logic        MemWr_dmem,
  input  logic [31:0] Addr_dmem,
  input  logic [3:0]  Conf_dmem,
  input  logic [31:0] data_in_dmem,
  output logic [31:0] data_out_dmem,
  output logic        init_busy,
  output logic        err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              err_q, err_d;
  logic [31:0]       mem [Depth];

  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              is_ld, is_st, sz_b, sz_h, sz_w;
  logic              aligned, ld_ok, st_ok;
  logic [31:0]       rd_word, rd_shift, ld_data;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              clr_en, wr_en;

  assign offset   = Addr_dmem - BASE_ADDR;
  assign in_range = (Addr_dmem >= BASE_ADDR) && (Addr_dmem <= `DMEM_MAX) &&
                    ((offset >> (ADDR_W + 2)) == 32'd0);
  assign idx      = offset[ADDR_W+1:2];

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    case (Conf_dmem)
      `LDB_CONF, `LDBU_CONF: begin is_ld = 1'b1; sz_b = 1'b1; end
      `LDH_CONF, `LDHU_CONF: begin is_ld = 1'b1; sz_h = 1'b1; end
      `LDW_CONF:             begin is_ld = 1'b1; sz_w = 1'b1; end
      `STB_CONF:             begin is_st = 1'b1; sz_b = 1'b1; end
      `STH_CONF:             begin is_st = 1'b1; sz_h = 1'b1; end
      `STW_CONF:             begin is_st = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
  end

  assign aligned = sz_w ? (Addr_dmem[1:0] == 2'b00) :
                   sz_h ? (Addr_dmem[0] == 1'b0) : 1'b1;
  assign ld_ok   = in_range && is_ld && aligned;
  assign st_ok   = in_range && is_st && aligned;

  // Stores never share a cycle with loads, so the combinational read needs no bypass.
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {Addr_dmem[1:0], 3'b000};
  assign ld_data  = sz_b ? {24'b0, rd_shift[7:0]}  :
                    sz_h ? {16'b0, rd_shift[15:0]} : rd_word;

  always_comb begin
    be    = 4'b0000;
    wdata = data_in_dmem;
    if (sz_b) begin
      be    = 4'b0001 << Addr_dmem[1:0];
      wdata = {4{data_in_dmem[7:0]}};
    end else if (sz_h) begin
      be    = 4'b0011 << {Addr_dmem[1], 1'b0};
      wdata = {2{data_in_dmem[15:0]}};
    end else if (sz_w) begin
      be    = 4'b1111;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    data_out_d = data_out_q;
    err_d      = 1'b0;
    clr_en     = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      StInit: begin
        clr_en    = 1'b1;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        err_d     = MemRd_dmem | MemWr_dmem;
        if (clr_idx_q == ADDR_W'(Depth - 1)) state_d = StRun;
      end
      StRun: begin
        if (MemRd_dmem) begin
          data_out_d = ld_ok ? ld_data : 32'd0;
          err_d      = !ld_ok || MemWr_dmem;
        end else if (MemWr_dmem) begin
          wr_en = st_ok;
          err_d = !st_ok;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT_CLEAR ? StInit : StRun;
      clr_idx_q  <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; contents are defined only by the sweep and stores.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign data_out_dmem = data_out_q;
  assign err           = err_q;
  assign init_busy     = (state_q == StInit);

endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: byte-array reference model checked every cycle, directed literal cases,
// then randomized requests including a reset in the middle of traffic.

`ifndef DMEM_MIN
`define DMEM_MIN 32'h0001_0000
`endif
`ifndef DMEM_MAX
`define DMEM_MAX 32'h0001_FFFF
`endif
`ifndef LDB_CONF
`define LDB_CONF  4'd0
`define LDH_CONF  4'd1
`define LDW_CONF  4'd2
`define LDBU_CONF 4'd3
`define LDHU_CONF 4'd4
`define STB_CONF  4'd5
`define STH_CONF  4'd6
`define STW_CONF  4'd7
`endif

module tb_dmem_bank;

  localparam int unsigned AW = 4;
  localparam logic [31:0] B  = `DMEM_MIN;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRd_dmem = 1'b0;
  logic        MemWr_dmem = 1'b0;
  logic [31:0] Addr_dmem = B;
  logic [3:0]  Conf_dmem = 4'd0;
  logic [31:0] data_in_dmem = 32'd0;
  logic [31:0] data_out_dmem;
  logic        init_busy;
  logic        err;

  dmem_bank #(
    .ADDR_W    (AW),
    .BASE_ADDR (B),
    .INIT_CLEAR(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRd_dmem   (MemRd_dmem),
    .MemWr_dmem   (MemWr_dmem),
    .Addr_dmem    (Addr_dmem),
    .Conf_dmem    (Conf_dmem),
    .data_in_dmem (data_in_dmem),
    .data_out_dmem(data_out_dmem),
    .init_busy    (init_busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as 64 bytes, outputs computed from the access rules.
  logic [7:0]  m_bytes [64];
  logic        m_busy = 1'b1;
  int          m_cnt  = 0;
  logic [31:0] m_dout = 32'd0;
  logic        m_err  = 1'b0;

  task automatic model_run();
    longint      off;
    int          sz;
    bit          ld_c, st_c, rng, algn, ok;
    logic [31:0] v;
    off  = longint'(Addr_dmem) - longint'(B);
    sz   = 1;
    ld_c = 0;
    st_c = 0;
    case (Conf_dmem)
      `LDB_CONF, `LDBU_CONF: begin sz = 1; ld_c = 1; end
      `LDH_CONF, `LDHU_CONF: begin sz = 2; ld_c = 1; end
      `LDW_CONF:             begin sz = 4; ld_c = 1; end
      `STB_CONF:             begin sz = 1; st_c = 1; end
      `STH_CONF:             begin sz = 2; st_c = 1; end
      `STW_CONF:             begin sz = 4; st_c = 1; end
      default: ;
    endcase
    rng   = (Addr_dmem >= B) && (Addr_dmem <= `DMEM_MAX) && (off >= 0) && (off < 64);
    algn  = (Addr_dmem % sz) == 0;
    m_err = 1'b0;
    if (MemRd_dmem) begin
      ok = rng && ld_c && algn;
      v  = 32'd0;
      if (ok) for (int k = 0; k < sz; k++) v |= 32'(m_bytes[off + k]) << (8 * k);
      m_dout = v;
      m_err  = !ok || MemWr_dmem;
    end else if (MemWr_dmem) begin
      ok = rng && st_c && algn;
      if (ok) for (int k = 0; k < sz; k++) m_bytes[off + k] = 8'(data_in_dmem >> (8 * k));
      m_err = !ok;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_dout = 32'd0;
      m_err  = 1'b0;
    end else if (m_busy) begin
      for (int k = 0; k < 4; k++) m_bytes[m_cnt*4 + k] = 8'd0;
      m_err = MemRd_dmem | MemWr_dmem;
      m_cnt++;
      if (m_cnt == 16) m_busy = 1'b0;
    end else begin
      model_run();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("init_busy", {31'd0, init_busy}, {31'd0, m_busy});
      check("err", {31'd0, err}, {31'd0, m_err});
      check("data_out", data_out_dmem, m_dout);
    end
  end

  task automatic idle();
    MemRd_dmem   = 1'b0;
    MemWr_dmem   = 1'b0;
    Conf_dmem    = 4'd0;
    Addr_dmem    = B;
    data_in_dmem = 32'd0;
  endtask

  task automatic req(input bit rd, input bit wr, input logic [3:0] conf,
                     input logic [31:0] addr, input logic [31:0] data);
    MemRd_dmem   = rd;
    MemWr_dmem   = wr;
    Conf_dmem    = conf;
    Addr_dmem    = addr;
    data_in_dmem = data;
    @(negedge clk);
    idle();
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic expect_out(input string name, input logic [31:0] d, input logic e);
    check({name, "_data"}, data_out_dmem, d);
    check({name, "_err"}, {31'd0, err}, {31'd0, e});
    check({name, "_mdata"}, m_dout, d);
    check({name, "_merr"}, {31'd0, m_err}, {31'd0, e});
  endtask

  task automatic wait_sweep(input string name);
    int cyc;
    cyc = 0;
    while (cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (!init_busy) break;
    end
    check(name, cyc, 16);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete, n_errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    bit          rd, wr;
    int          r;
    logic [3:0]  conf;
    logic [31:0] addr;

    idle();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wait_sweep("sweep_len");

    for (int w = 0; w < 16; w++) begin
      req(1, 0, `LDW_CONF, B + 32'(4 * w), 0);
      expect_out("ldw_zero", 32'h0, 1'b0);
    end

    req(0, 1, `STW_CONF, B, 32'h1122_3344);
    req(1, 0, `LDB_CONF, B + 0, 0);  expect_out("ldb0", 32'h44, 1'b0);
    req(1, 0, `LDBU_CONF, B + 1, 0); expect_out("ldb1", 32'h33, 1'b0);
    req(1, 0, `LDB_CONF, B + 2, 0);  expect_out("ldb2", 32'h22, 1'b0);
    req(1, 0, `LDB_CONF, B + 3, 0);  expect_out("ldb3", 32'h11, 1'b0);
    req(1, 0, `LDH_CONF, B + 2, 0);  expect_out("ldh2", 32'h0000_1122, 1'b0);

    req(0, 1, `STW_CONF, B + 4, 32'hFFFF_FFFF);
    req(0, 1, `STB_CONF, B + 5, 32'h0000_00AB);
    req(1, 0, `LDW_CONF, B + 4, 0);  expect_out("stb_merge", 32'hFFFF_ABFF, 1'b0);

    req(0, 1, `STW_CONF, B + 8, 32'h5566_7788);
    req(0, 1, `STH_CONF, B + 9, 32'h0000_BEEF);
    check("sth_misalign_err", {31'd0, err}, 32'd1);
    req(1, 0, `LDW_CONF, B + 8, 0);  expect_out("sth_dropped", 32'h5566_7788, 1'b0);
    req(1, 0, `LDW_CONF, B + 10, 0); expect_out("ldw_misalign", 32'h0, 1'b1);
    req(1, 0, `LDW_CONF, B + 64, 0); expect_out("ldw_oor", 32'h0, 1'b1);
    req(1, 0, `STW_CONF, B, 0);      expect_out("conf_mismatch", 32'h0, 1'b1);

    req(1, 1, `LDW_CONF, B, 32'h1234_5678);
    expect_out("rdwr_both", 32'h1122_3344, 1'b1);
    req(1, 0, `LDW_CONF, B, 0);      expect_out("rdwr_store_drop", 32'h1122_3344, 1'b0);

    req(0, 1, `STW_CONF, B + 12, 32'hDEAD_BEEF);
    req(1, 0, `LDW_CONF, B + 12, 0); expect_out("raw", 32'hDEAD_BEEF, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_idle", data_out_dmem, 32'hDEAD_BEEF);

    // Reset, release, then reset again partway through the sweep.
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("reset_dout", data_out_dmem, 32'h0);
    req(1, 0, `LDW_CONF, B, 0);
    check("init_drop_err", {31'd0, err}, 32'd1);
    check("init_busy_mid", {31'd0, init_busy}, 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    wait_sweep("sweep_restart");
    req(1, 0, `LDW_CONF, B + 12, 0); expect_out("cleared_after_restart", 32'h0, 1'b0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      r  = int'($urandom_range(0, 9));
      rd = (r <= 3) || (r == 8);
      wr = (r >= 4 && r <= 8);
      case ($urandom_range(0, 9))
        0:       addr = B + 32'($urandom_range(64, 80));
        1:       addr = B - 32'($urandom_range(1, 8));
        2, 3, 4: addr = (B + 32'($urandom_range(0, 63))) & ~32'h3;
        default: addr = B + 32'($urandom_range(0, 63));
      endcase
      conf = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      if (rd && !wr && $urandom_range(0, 3) != 0) conf = 4'($urandom_range(0, 4));
      if (wr && !rd && $urandom_range(0, 3) != 0) conf = 4'($urandom_range(5, 7));
      req(rd, wr, conf, addr, $urandom);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Single-port data memory that answers the LSU's DMEM request interface: it accepts one load or one committed store per cycle and returns load data one cycle later. It decodes the `*_CONF` access size, steers store bytes onto the correct byte lanes, and right-aligns load data to bit 0 so the LSU only has to apply sign or zero extension. After reset it zeroes its contents with an internal sweep, holding `init_busy` high until the sweep completes.

## Interface
- `ADDR_W`, 12: word-index width. Depth is 2^ADDR_W 32-bit words.
- `BASE_ADDR`, `` `DMEM_MIN ``: byte address of word 0.
- `INIT_CLEAR`, 1: 1 runs the zeroing sweep after reset; 0 starts directly in RUN.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `MemRd_dmem` in 1: load request this cycle.
- `MemWr_dmem` in 1: store request this cycle.
- `Addr_dmem` in 32: byte address.
- `Conf_dmem` in 4: access type, using the `*_CONF` macros in defs.svh.
- `data_in_dmem` in 32: store data, with the meaningful bits in the low byte, half or word.
- `data_out_dmem` out 32: registered load data, right-aligned, with upper bits zero.
- `init_busy` out 1: 1 while the zeroing sweep is running.
- `err` out 1: registered one-cycle pulse flagging a dropped or illegal request.

## Operation
- In-range check: the address is in range when `Addr_dmem` ≥ BASE_ADDR, `Addr_dmem` ≤ `` `DMEM_MAX ``, and (Addr−BASE_ADDR)>>2 < 2^ADDR_W.
- Word index = (Addr−BASE_ADDR)[ADDR_W+1:2].
- FSM has two states, INIT and RUN.
  - INIT: a counter clr_idx counts 0..2^ADDR_W−1 and writes 0 to one word per cycle. Requests are dropped and `err` pulses for each dropped request.
  - When clr_idx reaches the last index, its write completes, the FSM moves to RUN and `init_busy` falls.
- Stores (RUN state, MemWr=1, MemRd=0, in range). Byte enables and data placement:
  - STB: byte lane Addr[1:0] gets data_in[7:0].
  - STH: requires Addr[0]=0. Lanes {2·Addr[1], 2·Addr[1]+1} get data_in[15:0].
  - STW: requires Addr[1:0]=0. All lanes get data_in.
  - Lanes that are not enabled keep their previous value.
- Loads (RUN state, MemRd=1, in range):
  - LDB/LDBU: data_out = {24'b0, byte at lane Addr[1:0]}.
  - LDH/LDHU: requires Addr[0]=0. data_out = {16'b0, half selected by Addr[1]}.
  - LDW: requires Addr[1:0]=0. data_out = whole word.
- Error cases. `err` pulses the cycle after each of these:
  - Misaligned access, out-of-range access, or a Conf that does not match the request type. The write is dropped, and a load returns data_out=0.
  - MemRd and MemWr asserted together, which the protocol forbids. The load is served and the store is dropped.
- `data_out_dmem` updates only on a cycle that has MemRd=1. Otherwise it holds its last value.

## Timing
- Reset values: data_out_dmem=0, err=0, init_busy=INIT_CLEAR, state=INIT (or RUN if INIT_CLEAR=0), clr_idx=0. The memory array is not reset asynchronously; only the sweep clears it.
- Load latency is 1: a request at edge N produces data valid after edge N+1, stable for the whole cycle the LSU samples it combinationally.
- Store commits at the edge where it is presented.
- Read-after-write: a store at cycle N followed by a load of the same word at N+1 returns the new data. No bypass is needed because stores and loads never share a cycle.
- Sweep length is exactly 2^ADDR_W cycles from reset release to `init_busy`=0.
- Reset asserted mid-sweep or mid-operation restarts the sweep from clr_idx=0. A pending `err` or data_out is cleared.
- Throughput is one request per cycle, with no stall output.

## Test plan
All directed tests use ADDR_W=4.
- Reset release → init_busy=1 for exactly 16 cycles then 0. Then LDW of every word returns 0x00000000.
- STW 0x11223344 at BASE, then LDB at BASE+0..3 → 0x44, 0x33, 0x22, 0x11. LDH at BASE+2 → 0x00001122.
- STB 0xAB at BASE+5 over a word holding 0xFFFFFFFF → LDW at BASE+4 returns 0xFFFFABFF.
- STH at BASE+1 → err=1 next cycle and the memory word is unchanged. LDW at BASE+2 → err=1 and data_out=0.
- LDW at BASE+64 (out of range) → err=1 and data_out=0. MemRd and MemWr together → load served, store dropped, err=1.
- STW 0xDEADBEEF at cycle N, LDW of the same address at N+1 → 0xDEADBEEF. With no read, data_out holds across idle cycles. rst pulsed mid-sweep → init_busy stays high for 16 full cycles after release.
